// File: rtl/cv32e40p_lce_ctrl.sv
// LCE watchdog control: instruction-driven decrement prescaler, config/status
// registers, and alarm -> interrupt -> halt escalation state machine.
module cv32e40p_lce_ctrl #(
    parameter int PRESCALE_W = 16,
    parameter int ESC_CYCLES = 64,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    input  logic        instr_valid_i,
    input  logic        alarm_i,
    output logic        decrement_o,
    output logic        irq_o,
    input  logic        irq_ack_i,
    output logic        halt_req_o
);

    localparam int GW = $clog2(ESC_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ALERT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_ctrl;
    logic [2:0]            w_ctrl_nxt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  r_alarm_flag;
    logic [CNT_W-1:0]      r_acount;
    logic [GW-1:0]         r_grace;
    logic                  r_alarm_q;
    logic                  r_dec;
    logic                  r_irq;
    logic                  r_halt;

    logic        w_wr_ctrl;
    logic        w_wr_presc;
    logic        w_wr_acnt;
    logic        w_status_clr;
    logic        w_alarm_rise;
    logic        w_grace_done;
    logic        w_esc;
    logic        w_dec_fire;
    logic [31:0] w_rdata;
    logic        w_unused_wdata;

    assign w_wr_ctrl      = cfg_we_i && (cfg_addr_i == 2'd0);
    assign w_wr_presc     = cfg_we_i && (cfg_addr_i == 2'd1);
    assign w_status_clr   = cfg_we_i && (cfg_addr_i == 2'd2) && cfg_wdata_i[4];
    assign w_wr_acnt      = cfg_we_i && (cfg_addr_i == 2'd3);
    assign w_ctrl_nxt     = w_wr_ctrl ? cfg_wdata_i[2:0] : r_ctrl;
    assign w_alarm_rise   = alarm_i && !r_alarm_q;
    // Done one cycle early so HALT is entered on the edge the counter hits 0.
    assign w_grace_done   = (r_grace <= GW'(1));
    assign w_unused_wdata = ^cfg_wdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_ctrl_nxt[0]) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_ARMED;
                ST_ARMED: if (w_alarm_rise) w_state_nxt = ST_ALERT;
                ST_ALERT: begin
                    if (irq_ack_i) begin
                        w_state_nxt = ST_ARMED;
                    end else if (w_grace_done && w_ctrl_nxt[2]) begin
                        w_state_nxt = ST_HALT;
                    end
                end
                ST_HALT:  if (w_status_clr) w_state_nxt = ST_ARMED;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_esc      = (r_state == ST_ARMED) && (w_state_nxt == ST_ALERT);
    assign w_dec_fire = (r_state == ST_ARMED) && (w_state_nxt == ST_ARMED) &&
                        instr_valid_i && (r_pcnt == r_prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl       <= '0;
            r_prescale   <= '0;
            r_pcnt       <= '0;
            r_alarm_flag <= 1'b0;
            r_acount     <= '0;
            r_grace      <= '0;
            r_alarm_q    <= 1'b0;
            r_dec        <= 1'b0;
            r_irq        <= 1'b0;
            r_halt       <= 1'b0;
        end else begin
            r_ctrl    <= w_ctrl_nxt;
            r_alarm_q <= alarm_i;
            r_dec     <= w_dec_fire;
            r_irq     <= ((w_state_nxt == ST_ALERT) || (w_state_nxt == ST_HALT)) && w_ctrl_nxt[1];
            r_halt    <= (w_state_nxt == ST_HALT);

            if (w_wr_presc) begin
                r_prescale <= cfg_wdata_i[PRESCALE_W-1:0];
            end

            if ((r_state != ST_ARMED) || w_wr_presc) begin
                r_pcnt <= '0;
            end else if (instr_valid_i) begin
                r_pcnt <= (r_pcnt == r_prescale) ? '0 : r_pcnt + PRESCALE_W'(1);
            end

            if (w_esc) begin
                r_alarm_flag <= 1'b1;
            end else if (w_status_clr) begin
                r_alarm_flag <= 1'b0;
            end

            if (w_wr_acnt) begin
                r_acount <= '0;
            end else if (w_esc && (r_acount != {CNT_W{1'b1}})) begin
                r_acount <= r_acount + CNT_W'(1);
            end

            if (w_esc) begin
                r_grace <= GW'(ESC_CYCLES);
            end else if ((r_state == ST_ALERT) && (r_grace != '0)) begin
                r_grace <= r_grace - GW'(1);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (cfg_addr_i)
            2'd0: w_rdata[2:0] = r_ctrl;
            2'd1: w_rdata[PRESCALE_W-1:0] = r_prescale;
            2'd2: begin
                w_rdata[1:0] = r_state;
                w_rdata[4]   = r_alarm_flag;
            end
            default: w_rdata[CNT_W-1:0] = r_acount;
        endcase
    end

    assign cfg_rdata_o = w_rdata;
    assign decrement_o = r_dec;
    assign irq_o       = r_irq;
    assign halt_req_o  = r_halt;

endmodule

// File: tb/tb_cv32e40p_lce_ctrl.sv
// Randomized scoreboard bench for cv32e40p_lce_ctrl with a cycle-level reference
// model built from elapsed-cycle and event counts.
module tb_cv32e40p_lce_ctrl;

    localparam int PRESCALE_W = 16;
    localparam int ESC_CYCLES = 64;
    localparam int CNT_W      = 8;
    localparam int ACNT_MAX   = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_addr_i = 2'd0;
    logic [31:0] cfg_wdata_i = 32'd0;
    logic [31:0] cfg_rdata_o;
    logic        instr_valid_i = 1'b0;
    logic        alarm_i = 1'b0;
    logic        decrement_o;
    logic        irq_o;
    logic        irq_ack_i = 1'b0;
    logic        halt_req_o;

    always #5 clk = ~clk;

    cv32e40p_lce_ctrl #(
        .PRESCALE_W(PRESCALE_W),
        .ESC_CYCLES(ESC_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we_i(cfg_we_i),
        .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o),
        .instr_valid_i(instr_valid_i),
        .alarm_i(alarm_i),
        .decrement_o(decrement_o),
        .irq_o(irq_o),
        .irq_ack_i(irq_ack_i),
        .halt_req_o(halt_req_o)
    );

    int checks = 0;
    int failures = 0;
    int dec_seen = 0;
    bit halt_seen = 1'b0;

    logic [31:0] exp_q[$];
    logic [1:0]  rd_addr_q[$];
    logic [2:0]  out_q[$];

    // Reference model state: states as 0..3, prescaler as a running count of
    // valid cycles, grace as number of ALERT cycles already spent.
    int m_ctrl, m_presc, m_flag, m_acnt, m_state, m_vcnt, m_alert_cyc;
    bit m_alarm_prev;

    task automatic model_step();
        int  new_ctrl;
        int  nstate;
        bit  wr_presc, wr_acnt, clr, rise, esc, fire, irq_e;
        wr_presc = cfg_we_i && (cfg_addr_i == 2'd1);
        wr_acnt  = cfg_we_i && (cfg_addr_i == 2'd3);
        clr      = cfg_we_i && (cfg_addr_i == 2'd2) && cfg_wdata_i[4];
        new_ctrl = (cfg_we_i && cfg_addr_i == 2'd0) ? int'(cfg_wdata_i[2:0]) : m_ctrl;
        rise     = alarm_i && !m_alarm_prev;

        nstate = m_state;
        if ((new_ctrl & 1) == 0) nstate = 0;
        else if (m_state == 0) nstate = 1;
        else if (m_state == 1) nstate = rise ? 2 : 1;
        else if (m_state == 2) begin
            if (irq_ack_i) nstate = 1;
            else if ((m_alert_cyc + 1 >= ESC_CYCLES) && ((new_ctrl & 4) != 0)) nstate = 3;
            else nstate = 2;
        end else nstate = clr ? 1 : 3;

        esc  = (m_state == 1) && (nstate == 2);
        fire = (m_state == 1) && (nstate == 1) && instr_valid_i &&
               (((m_vcnt + 1) % (m_presc + 1)) == 0);

        if (m_state != 1 || wr_presc) m_vcnt = 0;
        else if (instr_valid_i) m_vcnt = m_vcnt + 1;

        if (esc) m_alert_cyc = 0;
        else if (m_state == 2) m_alert_cyc = m_alert_cyc + 1;

        if (esc) m_flag = 1;
        else if (clr) m_flag = 0;

        if (wr_acnt) m_acnt = 0;
        else if (esc && m_acnt < ACNT_MAX) m_acnt = m_acnt + 1;

        if (wr_presc) m_presc = int'(cfg_wdata_i) & ((1 << PRESCALE_W) - 1);

        irq_e = (nstate >= 2) && ((new_ctrl & 2) != 0);
        out_q.push_back({fire, irq_e, (nstate == 3)});

        m_ctrl       = new_ctrl;
        m_state      = nstate;
        m_alarm_prev = alarm_i;
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0: return 32'(m_ctrl);
            2'd1: return 32'(m_presc);
            2'd2: return 32'((m_flag << 4) | m_state);
            default: return 32'(m_acnt);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 0; m_presc = 0; m_flag = 0; m_acnt = 0;
            m_state = 0; m_vcnt = 0; m_alert_cyc = 0; m_alarm_prev = 1'b0;
            out_q.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: pops one expected output vector per cycle and one expected read
    // value whenever a read was issued.
    always @(negedge clk) begin
        logic [2:0]  e3;
        logic [31:0] e32;
        logic [1:0]  ra;
        if (decrement_o) dec_seen++;
        if (halt_req_o) halt_seen = 1'b1;
        if (out_q.size() > 0) begin
            e3 = out_q.pop_front();
            checks++;
            if ({decrement_o, irq_o, halt_req_o} !== e3) begin
                failures++;
                $display("FAIL outputs t=%0t {dec,irq,halt} got=%b exp=%b", $time,
                         {decrement_o, irq_o, halt_req_o}, e3);
            end
        end
        if (exp_q.size() > 0) begin
            e32 = exp_q.pop_front();
            ra  = rd_addr_q.pop_front();
            checks++;
            if (cfg_rdata_o !== e32) begin
                failures++;
                $display("FAIL read addr%0d t=%0t got=0x%0h exp=0x%0h", ra, $time, cfg_rdata_o, e32);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        step();
        cfg_we_i    = 1'b0;
        cfg_wdata_i = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a);
        cfg_addr_i = a;
        exp_q.push_back(model_rd(a));
        rd_addr_q.push_back(a);
        step();
    endtask

    task automatic reach_halt();
        alarm_i = 1'b1;
        step();
        repeat (ESC_CYCLES + 2) step();
        alarm_i = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        rst_n = 1'b0;
        step();
        chk("reset_outputs", {29'd0, decrement_o, irq_o, halt_req_o}, 32'd0);
        for (int a = 0; a < 4; a++) rd(2'(a));
        rst_n = 1'b1;
        step();

        // Prescaler: PRESCALE=3, 12 valid cycles -> 3 pulses
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        rd(2'd2);
        dec_seen = 0;
        instr_valid_i = 1'b1;
        repeat (12) step();
        instr_valid_i = 1'b0;
        repeat (2) step();
        chk("dec_pulses_p3", 32'(dec_seen), 32'd3);

        // Randomized prescale values and retire patterns
        for (int r = 0; r < 4; r++) begin
            wr(2'd1, 32'($urandom_range(0, 4)));
            repeat (40) begin
                instr_valid_i = 1'($urandom_range(0, 1));
                step();
            end
        end
        instr_valid_i = 1'b0;

        // Alarm -> IRQ -> ack, held alarm does not re-trigger
        wr(2'd0, 32'h3);
        alarm_i = 1'b1;
        step();
        chk("irq_after_rise", 32'(irq_o), 32'd1);
        rd(2'd2);
        rd(2'd3);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        chk("irq_after_ack", 32'(irq_o), 32'd0);
        repeat (5) step();
        rd(2'd2);
        rd(2'd3);
        alarm_i = 1'b0;
        step();

        // Halt escalation latency
        wr(2'd0, 32'h7);
        alarm_i = 1'b1;
        step();
        n = 0;
        while (!halt_req_o && n < 100) begin
            step();
            n++;
        end
        chk("halt_latency", 32'(n), 32'(ESC_CYCLES));
        alarm_i = 1'b0;
        rd(2'd2);
        wr(2'd2, 32'h10);
        rd(2'd2);
        chk("halt_cleared", 32'(halt_req_o), 32'd0);

        // Ack in the same cycle the grace counter expires
        halt_seen = 1'b0;
        alarm_i = 1'b1;
        step();
        repeat (ESC_CYCLES - 1) step();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        alarm_i = 1'b0;
        step();
        chk("ack_vs_expiry_halt", 32'(halt_seen), 32'd0);
        cfg_addr_i = 2'd2;
        #1;
        chk("ack_vs_expiry_state", 32'(cfg_rdata_o[1:0]), 32'd1);
        rd(2'd2);

        // CTRL=0 during HALT
        reach_halt();
        chk("halt_before_disable", 32'(halt_req_o), 32'd1);
        wr(2'd0, 32'h0);
        chk("disable_outputs", {29'd0, decrement_o, irq_o, halt_req_o}, 32'd0);
        rd(2'd2);

        // Alarm counter saturation
        wr(2'd0, 32'h1);
        for (int i = 0; i < ACNT_MAX + 4; i++) begin
            alarm_i = 1'b1;
            step();
            irq_ack_i = 1'b1;
            step();
            irq_ack_i = 1'b0;
            alarm_i = 1'b0;
            step();
        end
        cfg_addr_i = 2'd3;
        #1;
        chk("acount_saturated", cfg_rdata_o, 32'(ACNT_MAX));
        rd(2'd3);
        wr(2'd3, 32'h5a);
        rd(2'd3);

        // Random mixed traffic
        wr(2'd0, 32'h3);
        for (int c = 0; c < 800; c++) begin
            logic [1:0] a;
            instr_valid_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) alarm_i = ~alarm_i;
            irq_ack_i = ($urandom_range(0, 9) == 0);
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) begin
                cfg_we_i   = 1'b1;
                cfg_addr_i = a;
                case (a)
                    2'd0: cfg_wdata_i = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                         1'($urandom_range(0, 7) != 0)};
                    2'd1: cfg_wdata_i = 32'($urandom_range(0, 3));
                    default: cfg_wdata_i = $urandom;
                endcase
                step();
                cfg_we_i    = 1'b0;
                cfg_wdata_i = 32'd0;
            end else if ($urandom_range(0, 5) == 0) begin
                rd(a);
            end else begin
                step();
            end
        end
        instr_valid_i = 1'b0;
        irq_ack_i = 1'b0;
        alarm_i = 1'b0;
        step();

        // Asynchronous reset in the middle of HALT
        wr(2'd0, 32'h7);
        step();
        reach_halt();
        chk("halt_before_reset", {30'd0, irq_o, halt_req_o}, 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {29'd0, decrement_o, irq_o, halt_req_o}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int a = 0; a < 4; a++) rd(2'(a));
        cfg_addr_i = 2'd0;
        #1;
        chk("ctrl_after_reset", cfg_rdata_o, 32'd0);
        repeat (3) step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
